// File: rtl/requant_scaler.sv
// Requantising scaler: signed accumulator results are multiplied by a runtime scale,
// rounded/shifted, offset and clamped to an unsigned index/value/enable stream.
module requant_scaler #(
   parameter int                     DATA_WIDTH    = 8,
   parameter int                     RESULT_WIDTH  = 21,
   parameter int                     SCALE_WIDTH   = 16,
   parameter int                     CELL_AMOUNT   = 4,
   parameter logic [SCALE_WIDTH-1:0] DEFAULT_SCALE = 16'd20837,
   parameter logic [7:0]             DEFAULT_SHIFT = 8'd23,
   parameter int                     OUTPUT_OFFSET = 0,
   parameter int                     ROUND_MODE    = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic signed [RESULT_WIDTH-1:0] input_result,
   input  logic                           input_enable,
   input  logic                           cfg_load,
   input  logic        [SCALE_WIDTH-1:0]  cfg_scale,
   input  logic        [7:0]              cfg_shift,
   output logic        [DATA_WIDTH-1:0]   output_index,
   output logic        [DATA_WIDTH-1:0]   output_value,
   output logic                           output_enable,
   output logic                           output_last,
   output logic        [15:0]             sat_count,
   output logic                           busy
);

   localparam int PW = RESULT_WIDTH + SCALE_WIDTH + 1;
   localparam int EW = PW + 1;
   localparam logic [7:0] MAX_SHIFT = 8'(RESULT_WIDTH + SCALE_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(CELL_AMOUNT - 1);
   localparam logic signed [EW-1:0] OUT_MAX = EW'((1 << DATA_WIDTH) - 1);
   localparam logic signed [EW-1:0] OFFSET  = EW'(OUTPUT_OFFSET);
   localparam logic signed [EW-1:0] ONE     = EW'(1);

   logic [SCALE_WIDTH-1:0] scale_q;
   logic [7:0]             shift_q;
   logic signed [PW-1:0]   prod_q, prod_d;
   logic                   v1_q;
   logic [DATA_WIDTH-1:0]  idx_q, idx_d;
   logic [DATA_WIDTH-1:0]  out_idx_q, out_val_q, val_d;
   logic                   out_en_q, out_last_q;
   logic [15:0]            sat_q;
   logic                   sat_d;

   logic signed [PW-1:0] res_ext, scl_ext;
   logic signed [EW-1:0] half, biased, shifted, offs;

   // The scale is zero-extended so the signed multiply treats it as unsigned.
   assign res_ext = {{(PW-RESULT_WIDTH){input_result[RESULT_WIDTH-1]}}, input_result};
   assign scl_ext = {{(PW-SCALE_WIDTH){1'b0}}, scale_q};
   assign prod_d  = res_ext * scl_ext;

   assign busy = v1_q | (idx_q != '0);

   always_comb begin
      half = '0;
      if (ROUND_MODE != 0) begin
         half = ONE << (shift_q - 8'd1);
      end
      biased  = {prod_q[PW-1], prod_q} + half;
      shifted = biased >>> shift_q;
      offs    = shifted + OFFSET;
      sat_d   = 1'b0;
      val_d   = offs[DATA_WIDTH-1:0];
      if (offs < 0) begin
         val_d = '0;
         sat_d = 1'b1;
      end else if (offs > OUT_MAX) begin
         val_d = '1;
         sat_d = 1'b1;
      end
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
   end

   // Config only changes with nothing in flight, so stage 2 can use shift_q directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scale_q <= DEFAULT_SCALE;
         shift_q <= DEFAULT_SHIFT;
      end else if (cfg_load && !busy && !input_enable) begin
         scale_q <= cfg_scale;
         if (cfg_shift != 8'd0 && cfg_shift <= MAX_SHIFT) begin
            shift_q <= cfg_shift;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         v1_q   <= 1'b0;
      end else begin
         v1_q <= input_enable;
         if (input_enable) begin
            prod_q <= prod_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         out_idx_q  <= '0;
         out_val_q  <= '0;
         out_en_q   <= 1'b0;
         out_last_q <= 1'b0;
         sat_q      <= '0;
      end else begin
         out_en_q   <= v1_q;
         out_last_q <= v1_q && (idx_q == LAST_IDX);
         if (v1_q) begin
            out_idx_q <= idx_q;
            out_val_q <= val_d;
            idx_q     <= idx_d;
            if (sat_d && sat_q != 16'hFFFF) begin
               sat_q <= sat_q + 16'd1;
            end
         end
      end
   end

   assign output_index  = out_idx_q;
   assign output_value  = out_val_q;
   assign output_enable = out_en_q;
   assign output_last   = out_last_q;
   assign sat_count     = sat_q;

endmodule

// File: tb/tb_requant_scaler.sv
// Directed bench for requant_scaler: a round-half-up and a truncating instance share stimulus.
module tb_requant_scaler;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [20:0] input_result = '0;
   logic               input_enable = 1'b0;
   logic               cfg_load = 1'b0;
   logic        [15:0] cfg_scale = '0;
   logic        [7:0]  cfg_shift = '0;

   logic [7:0]  output_index, output_value;
   logic        output_enable, output_last, busy;
   logic [15:0] sat_count;

   logic [7:0]  t_index, t_value;
   logic        t_enable, t_last, t_busy;
   logic [15:0] t_sat;

   int tests_run = 0;
   int tests_failed = 0;

   requant_scaler #(.ROUND_MODE(1)) dut (
      .clk(clk), .rst_n(rst_n), .input_result(input_result), .input_enable(input_enable),
      .cfg_load(cfg_load), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
      .output_index(output_index), .output_value(output_value), .output_enable(output_enable),
      .output_last(output_last), .sat_count(sat_count), .busy(busy)
   );

   requant_scaler #(.ROUND_MODE(0)) dut_trunc (
      .clk(clk), .rst_n(rst_n), .input_result(input_result), .input_enable(input_enable),
      .cfg_load(cfg_load), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
      .output_index(t_index), .output_value(t_value), .output_enable(t_enable),
      .output_last(t_last), .sat_count(t_sat), .busy(t_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic en, input logic signed [20:0] r);
      input_enable = en;
      input_result = r;
   endtask

   task automatic do_reset();
      drive(1'b0, '0);
      cfg_load = 1'b0;
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic load_cfg(input logic [15:0] s, input logic [7:0] sh);
      cfg_load = 1'b1;
      cfg_scale = s;
      cfg_shift = sh;
      cycle();
      cfg_load = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] idx, input logic [7:0] val,
                          input logic last);
      chk({tag, ".en"}, 32'(output_enable), 32'd1);
      chk({tag, ".idx"}, 32'(output_index), 32'(idx));
      chk({tag, ".val"}, 32'(output_value), 32'(val));
      chk({tag, ".last"}, 32'(output_last), 32'(last));
   endtask

   logic [15:0] en_pat = 16'h3333;
   int          cnt, held, lasts;

   initial begin
      @(negedge clk);
      chk("rst.en", 32'(output_enable), 0);
      chk("rst.val", 32'(output_value), 0);
      chk("rst.idx", 32'(output_index), 0);
      chk("rst.sat", 32'(sat_count), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.last", 32'(output_last), 0);
      rst_n = 1'b1;

      // Default config, back-to-back layer of four.
      drive(1'b1, 21'sd100000);  cycle();
      chk("t1.idle", 32'(output_enable), 0);
      drive(1'b1, 21'sd50000);   cycle();
      chk_out("t1.o0", 8'd0, 8'd248, 1'b0);
      chk("t1.o0.trunc", 32'(t_value), 248);
      drive(1'b1, 21'sd1000);    cycle();
      chk_out("t1.o1", 8'd1, 8'd124, 1'b0);
      drive(1'b1, -21'sd1000);   cycle();
      chk_out("t1.o2", 8'd2, 8'd2, 1'b0);
      chk("t1.o2.trunc", 32'(t_value), 2);
      drive(1'b0, '0);           cycle();
      chk_out("t1.o3", 8'd3, 8'd0, 1'b1);
      chk("t1.sat", 32'(sat_count), 1);
      chk("t1.trunc.idx", 32'(t_index), 3);
      chk("t1.trunc.last", 32'(t_last), 1);
      chk("t1.trunc.sat", 32'(t_sat), 1);
      cycle();
      chk("t1.hold.en", 32'(output_enable), 0);
      chk("t1.hold.val", 32'(output_value), 0);
      chk("t1.hold.idx", 32'(output_index), 3);
      chk("t1.busy", 32'(busy), 0);

      // Positive overflow clamps to the top code.
      drive(1'b1, 21'sd500000);  cycle();
      drive(1'b0, '0);           cycle();
      chk_out("t2", 8'd0, 8'd255, 1'b0);
      chk("t2.sat", 32'(sat_count), 2);
      chk("t2.busy", 32'(busy), 1);

      // Runtime scale=1 shift=1: rounding vs truncation.
      do_reset();
      chk("t3.rst.sat", 32'(sat_count), 0);
      load_cfg(16'd1, 8'd1);
      drive(1'b1, 21'sd5);       cycle();
      drive(1'b1, -21'sd5);      cycle();
      chk_out("t3.p5", 8'd0, 8'd3, 1'b0);
      chk("t3.p5.trunc", 32'(t_value), 2);
      drive(1'b0, '0);           cycle();
      chk_out("t3.m5", 8'd1, 8'd0, 1'b0);
      chk("t3.m5.trunc", 32'(t_value), 0);
      chk("t3.sat", 32'(sat_count), 1);
      chk("t3.trunc.sat", 32'(t_sat), 1);

      // Out-of-range shift is dropped while the scale still loads.
      do_reset();
      load_cfg(16'd65535, 8'd37);
      drive(1'b1, 21'sd1048575); cycle();
      drive(1'b0, '0);           cycle();
      chk_out("t4.sh37", 8'd0, 8'd255, 1'b0);
      chk("t4.sh37.sat", 32'(sat_count), 1);
      do_reset();
      load_cfg(16'd65535, 8'd36);
      drive(1'b1, 21'sd1048575); cycle();
      drive(1'b0, '0);           cycle();
      chk_out("t4.sh36", 8'd0, 8'd1, 1'b0);
      chk("t4.sh36.trunc", 32'(t_value), 0);
      do_reset();
      load_cfg(16'd65535, 8'd0);
      drive(1'b1, 21'sd128);     cycle();
      drive(1'b0, '0);           cycle();
      chk_out("t4.sh0", 8'd0, 8'd1, 1'b0);
      chk("t4.sh0.trunc", 32'(t_value), 0);
      chk("t4.sh0.sat", 32'(sat_count), 0);

      // Pairs separated by two idle cycles: index only advances on outputs.
      do_reset();
      cnt = 0; held = 0; lasts = 0;
      for (int c = 0; c < 18; c++) begin
         if (c >= 2 && en_pat[c-2]) begin
            chk("t5.en", 32'(output_enable), 1);
            chk("t5.idx", 32'(output_index), 32'(cnt));
            chk("t5.last", 32'(output_last), (cnt == 3) ? 1 : 0);
            held = cnt;
            cnt = (cnt + 1) % 4;
         end else begin
            chk("t5.gap.en", 32'(output_enable), 0);
            chk("t5.gap.idx", 32'(output_index), 32'(held));
            chk("t5.gap.last", 32'(output_last), 0);
         end
         lasts += int'(output_last);
         drive((c < 16) ? en_pat[c] : 1'b0, 21'(c * 1000));
         cycle();
      end
      chk("t5.lasts", 32'(lasts), 2);

      // Load while busy, and load together with a sample, are both ignored.
      do_reset();
      drive(1'b1, 21'sd100000);  cycle();
      drive(1'b0, '0);
      chk("t6.busy", 32'(busy), 1);
      load_cfg(16'd1, 8'd1);
      chk_out("t6.o0", 8'd0, 8'd248, 1'b0);
      drive(1'b1, 21'sd50000);
      cfg_load = 1'b1;
      cycle();
      cfg_load = 1'b0;
      drive(1'b0, '0);           cycle();
      chk_out("t6.o1", 8'd1, 8'd124, 1'b0);
      drive(1'b1, 21'sd1000);    cycle();
      drive(1'b0, '0);           cycle();
      chk_out("t6.o2", 8'd2, 8'd2, 1'b0);

      // Asynchronous reset mid-layer between clock edges.
      do_reset();
      drive(1'b1, 21'sd100000);  cycle();
      drive(1'b1, 21'sd50000);   cycle();
      chk_out("t7.pre", 8'd0, 8'd248, 1'b0);
      drive(1'b0, '0);
      #1 rst_n = 1'b0;
      #2;
      chk("t7.async.en", 32'(output_enable), 0);
      chk("t7.async.val", 32'(output_value), 0);
      chk("t7.async.idx", 32'(output_index), 0);
      chk("t7.async.busy", 32'(busy), 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("t7.lost", 32'(output_enable), 0);
      drive(1'b1, 21'sd1000);    cycle();
      drive(1'b0, '0);           cycle();
      chk_out("t7.post", 8'd0, 8'd2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
